// File: rtl/int_to_float_conv.sv
// Sequential integer to IEEE-754 single converter: normalises one bit per clock
// with a valid/ready handshake on both sides and one conversion in flight.
module int_to_float_conv #(
  parameter int IN_W      = 16,
  parameter int SIGNED_IN = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data
);

  typedef enum logic [1:0] {IDLE, NORM, OUT} state_t;

  localparam logic [7:0] EXP_TOP = 8'(126 + IN_W);

  state_t          state, state_nx;
  logic [IN_W-1:0] mag, mag_nx;
  logic [7:0]      expo, expo_nx;
  logic            sign, sign_nx;
  logic            in_ready_nx, out_valid_nx;
  logic [31:0]     out_data_nx;
  logic [22:0]     frac;

  // Drop the implicit leading one and left-align the rest in the 23-bit field.
  assign frac = 23'({mag[IN_W-2:0], 24'b0} >> IN_W);

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nx     = state;
    mag_nx       = mag;
    expo_nx      = expo;
    sign_nx      = sign;
    in_ready_nx  = in_ready;
    out_valid_nx = out_valid;
    out_data_nx  = out_data;
    case (state)
      IDLE: begin
        in_ready_nx = 1'b1;
        if (in_valid && in_ready) begin
          in_ready_nx = 1'b0;
          sign_nx     = (SIGNED_IN != 0) && in_data[IN_W-1];
          mag_nx      = sign_nx ? -in_data : in_data;
          expo_nx     = EXP_TOP;
          state_nx    = NORM;
        end
      end
      NORM: begin
        // A zero input passes through here once so every result takes at least one cycle.
        if (mag[IN_W-1] || (mag == '0)) begin
          out_data_nx  = (mag == '0) ? 32'h0 : {sign, expo, frac};
          out_valid_nx = 1'b1;
          state_nx     = OUT;
        end else begin
          mag_nx  = mag << 1;
          expo_nx = expo - 8'd1;
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_nx = 1'b0;
          in_ready_nx  = 1'b1;
          state_nx     = IDLE;
        end
      end
      default: begin
        state_nx     = IDLE;
        in_ready_nx  = 1'b0;
        out_valid_nx = 1'b0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together
  // from the values sampled before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mag       <= '0;
      expo      <= '0;
      sign      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nx;
      mag       <= mag_nx;
      expo      <= expo_nx;
      sign      <= sign_nx;
      in_ready  <= in_ready_nx;
      out_valid <= out_valid_nx;
      out_data  <= out_data_nx;
    end
  end

endmodule
